// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, captures {pc, instr, fault} into a prefetch FIFO for decode.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        if_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_redirects
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0]    r_fetch_pc;
  logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]  r_count;
  logic [63:0]    r_pc_mem    [DEPTH];
  logic [31:0]    r_instr_mem [DEPTH];
  logic [DEPTH-1:0] r_fault_mem;

  logic w_full, w_pop, w_push, w_fault;
  logic w_unused_rpc_lsb;

  assign w_unused_rpc_lsb = &{1'b0, redirect_pc[1:0]};

  assign imem_addr = r_fetch_pc;
  assign if_valid  = (r_count != '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = if_valid && if_ready;
  assign w_push    = !redirect_valid && (!w_full || w_pop);
  assign w_fault   = (r_fetch_pc[63:2] >= 62'(IMEM_WORDS));

  assign if_instr = r_instr_mem[r_rd_ptr];
  assign if_pc    = r_pc_mem[r_rd_ptr];
  assign if_fault = r_fault_mem[r_rd_ptr];

  // Storage is cleared on reset so the head outputs read zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_fault_mem <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[63:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= w_fault ? NOP : imem_rdata;
        r_fault_mem[r_wr_ptr] <= w_fault;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
        r_fetch_pc            <= r_fetch_pc + 64'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stalls, r_perf_redirects;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched   <= '0;
      r_perf_stalls    <= '0;
      r_perf_redirects <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_full && !w_pop && !redirect_valid) r_perf_stalls <= r_perf_stalls + 32'd1;
      if (redirect_valid) r_perf_redirects <= r_perf_redirects + 32'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_stalls    = r_perf_stalls;
  assign perf_redirects = r_perf_redirects;
`else
  assign perf_fetched   = '0;
  assign perf_stalls    = '0;
  assign perf_redirects = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random traffic
// compared against a queue-based model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned IMEM_WORDS = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_fault;
  logic [31:0] perf_fetched, perf_stalls, perf_redirects;

  instruction_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .IMEM_WORDS(IMEM_WORDS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_fault      (if_fault),
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls),
    .perf_redirects(perf_redirects)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [IMEM_WORDS];
  assign imem_rdata = (imem_addr < 64'(IMEM_WORDS * 4)) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  logic [31:0] m_fetched, m_stalls, m_redirects;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t fetch_entry(input logic [63:0] pc);
    ent_t e;
    e.pc    = pc;
    e.fault = (pc >= 64'(IMEM_WORDS * 4));
    e.instr = e.fault ? 32'h0000_0013 : mem[pc[8:2]];
    return e;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit pop;
    pop = (q.size() > 0) && if_ready;
    if (redirect_valid) begin
      m_redirects++;
      q.delete();
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      bit can_push;
      can_push = (q.size() < DEPTH) || pop;
      if (!pop && q.size() == DEPTH) m_stalls++;
      if (pop) void'(q.pop_front());
      if (can_push) begin
        q.push_back(fetch_entry(m_pc));
        m_pc = m_pc + 64'd4;
        m_fetched++;
      end
    end
  endtask

  task automatic check_all();
    chk("if_valid", if_valid, q.size() > 0);
    chk("imem_addr", imem_addr, m_pc);
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
      chk("if_fault", if_fault, q[0].fault);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_stalls", perf_stalls, m_stalls);
    chk("perf_redirects", perf_redirects, m_redirects);
`else
    chk("perf_fetched", perf_fetched, 0);
    chk("perf_stalls", perf_stalls, 0);
    chk("perf_redirects", perf_redirects, 0);
`endif
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [63:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases away from an edge.
  task automatic do_reset();
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    #1;
    q.delete();
    m_pc        = RESET_PC;
    m_fetched   = '0;
    m_stalls    = '0;
    m_redirects = '0;
    chk("rst_valid", if_valid, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_fault", if_fault, 0);
    chk("rst_perf_f", perf_fetched, 0);
    chk("rst_perf_s", perf_stalls, 0);
    chk("rst_perf_r", perf_redirects, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_addr", imem_addr, RESET_PC);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = $urandom;
    #2;
    do_reset();

    // Sequential fetch with decode always ready
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, '0);
      chk("seq_pc", if_pc, 64'(4 * i));
      chk("seq_instr", if_instr, mem[i]);
    end

    // Backpressure fills the FIFO and freezes fetch
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
    chk("bp_valid", if_valid, 1);
    chk("bp_pc", if_pc, 0);
    chk("bp_addr", imem_addr, 64'h8);
`ifdef IFU_PERF_CNT_EN
    chk("bp_stalls", perf_stalls, 3);
`endif

    // Redirect while full, head consumed in the redirect cycle
    cycle(1'b1, 1'b1, 64'h40);
    chk("redir_valid", if_valid, 0);
    chk("redir_addr", imem_addr, 64'h40);
    cycle(1'b1, 1'b0, '0);
    chk("redir_pc0", if_pc, 64'h40);
    cycle(1'b1, 1'b0, '0);
    chk("redir_pc1", if_pc, 64'h44);

    // Misaligned redirect, then back-to-back redirects
    cycle(1'b1, 1'b1, 64'h43);
    chk("misal_addr", imem_addr, 64'h40);
    cycle(1'b1, 1'b0, '0);
    chk("misal_pc", if_pc, 64'h40);
    cycle(1'b1, 1'b1, 64'h10);
    cycle(1'b1, 1'b1, 64'h20);
    chk("b2b_valid", if_valid, 0);
    cycle(1'b1, 1'b0, '0);
    chk("b2b_pc", if_pc, 64'h20);

    // Range boundary
    cycle(1'b1, 1'b1, 64'h1FC);
    cycle(1'b1, 1'b0, '0);
    chk("edge_pc", if_pc, 64'h1FC);
    chk("edge_fault", if_fault, 0);
    cycle(1'b1, 1'b0, '0);
    chk("oor_pc", if_pc, 64'h200);
    chk("oor_fault", if_fault, 1);
    chk("oor_instr", if_instr, 32'h0000_0013);

    // PC wrap at the top of the address space
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_pc", if_pc, 64'h0);

    // Reset mid-stream with the FIFO full
    cycle(1'b0, 1'b1, 64'h80);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
    chk("full_before_rst", imem_addr, 64'h88);
    do_reset();
    cycle(1'b1, 1'b0, '0);
    chk("post_rst_pc", if_pc, RESET_PC);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        rdy, rv;
      logic [63:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 64'($urandom_range(0, 32'h220));
        1:       rpc = 64'(32'h1E8 + $urandom_range(0, 31));
        2:       rpc = {$urandom, $urandom};
        default: rpc = 64'($urandom_range(0, 63));
      endcase
      cycle(rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
